// File: rtl/matmul_tile_sequencer_pkg.sv
// Shared definitions for the matmul tile sequencer: FSM encoding, default sizes, tile byte size.
// The optional PERF_COUNTER_EN macro is consumed by matmul_tile_sequencer.sv.
package matmul_tile_sequencer_pkg;

    localparam int DEF_MAT_MUL_SIZE = 4;
    localparam int DEF_DWIDTH       = 8;
    localparam int DEF_ADDR_WIDTH   = 15;
    localparam int DEF_TILE_CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } seq_state_t;

    function automatic int tile_bytes(input int size, input int dwidth);
        return size * size * dwidth / 8;
    endfunction

    localparam int TILE_BYTES = tile_bytes(DEF_MAT_MUL_SIZE, DEF_DWIDTH);

endpackage

// File: rtl/matmul_tile_sequencer_tile_addr_gen.sv
// Tile index walker (k innermost, then n, then m) with incremental A/B/C base-address accumulators.
// Only adds and constant shifts are used; TILE_BYTES must be a power of two.
module matmul_tile_sequencer_tile_addr_gen #(
    parameter int ADDR_WIDTH = 15,
    parameter int TILE_CNT_W = 8,
    parameter int TILE_BYTES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  init_i,
    input  logic                  step_i,
    input  logic [TILE_CNT_W-1:0] cnt_m_i,
    input  logic [TILE_CNT_W-1:0] cnt_n_i,
    input  logic [TILE_CNT_W-1:0] cnt_k_i,
    input  logic [ADDR_WIDTH-1:0] base_a_i,
    input  logic [ADDR_WIDTH-1:0] base_b_i,
    input  logic [ADDR_WIDTH-1:0] base_c_i,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    output logic [ADDR_WIDTH-1:0] c_addr_o,
    output logic                  k_zero_o,
    output logic                  last_o
);

    localparam int SH = $clog2(TILE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] TB = ADDR_WIDTH'(TILE_BYTES);

    logic [TILE_CNT_W-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
    logic [ADDR_WIDTH-1:0] a_row_q, a_row_d, a_q, a_d;
    logic [ADDR_WIDTH-1:0] b_col_q, b_col_d, b_q, b_d, base_b_q, base_b_d;
    logic [ADDR_WIDTH-1:0] c_q, c_d;
    logic [ADDR_WIDTH-1:0] stride_a, stride_b;
    logic                  k_last, n_last, m_last;

    // stride_a moves A one tile-row (NK tiles); stride_b moves B one k step (NN tiles)
    assign stride_a = ADDR_WIDTH'(cnt_k_i) << SH;
    assign stride_b = ADDR_WIDTH'(cnt_n_i) << SH;
    assign k_last   = (k_q == cnt_k_i - 1'b1);
    assign n_last   = (n_q == cnt_n_i - 1'b1);
    assign m_last   = (m_q == cnt_m_i - 1'b1);

    always_comb begin
        m_d      = m_q;
        n_d      = n_q;
        k_d      = k_q;
        a_row_d  = a_row_q;
        a_d      = a_q;
        b_col_d  = b_col_q;
        b_d      = b_q;
        base_b_d = base_b_q;
        c_d      = c_q;
        if (init_i) begin
            m_d      = '0;
            n_d      = '0;
            k_d      = '0;
            a_row_d  = base_a_i;
            a_d      = base_a_i;
            b_col_d  = base_b_i;
            b_d      = base_b_i;
            base_b_d = base_b_i;
            c_d      = base_c_i;
        end else if (step_i) begin
            if (!k_last) begin
                k_d = k_q + 1'b1;
                a_d = a_q + TB;
                b_d = b_q + stride_b;
            end else begin
                k_d = '0;
                c_d = c_q + TB;
                if (!n_last) begin
                    n_d     = n_q + 1'b1;
                    a_d     = a_row_q;
                    b_col_d = b_col_q + TB;
                    b_d     = b_col_q + TB;
                end else begin
                    n_d     = '0;
                    m_d     = m_q + 1'b1;
                    a_row_d = a_row_q + stride_a;
                    a_d     = a_row_q + stride_a;
                    b_col_d = base_b_q;
                    b_d     = base_b_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_row_q  <= '0;
            a_q      <= '0;
            b_col_q  <= '0;
            b_q      <= '0;
            base_b_q <= '0;
            c_q      <= '0;
        end else begin
            m_q      <= m_d;
            n_q      <= n_d;
            k_q      <= k_d;
            a_row_q  <= a_row_d;
            a_q      <= a_d;
            b_col_q  <= b_col_d;
            b_q      <= b_d;
            base_b_q <= base_b_d;
            c_q      <= c_d;
        end
    end

    assign a_addr_o = a_q;
    assign b_addr_o = b_q;
    assign c_addr_o = c_q;
    assign k_zero_o = (k_q == '0);
    assign last_o   = k_last && n_last && m_last;

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Tiled matmul sequencer: launches the 4x4 engine once per (m,n,k) tile with registered tile addresses.
// Optional PERF_COUNTER_EN adds perf_cycles/perf_launches outputs.
module matmul_tile_sequencer
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int TILE_CNT_W   = DEF_TILE_CNT_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_reg,
    input  logic                  clear_done_reg,
    input  logic [TILE_CNT_W-1:0] num_tiles_m,
    input  logic [TILE_CNT_W-1:0] num_tiles_n,
    input  logic [TILE_CNT_W-1:0] num_tiles_k,
    input  logic [ADDR_WIDTH-1:0] base_addr_a,
    input  logic [ADDR_WIDTH-1:0] base_addr_b,
    input  logic [ADDR_WIDTH-1:0] base_addr_c,
    output logic                  start_mat_mul,
    input  logic                  done_mat_mul,
    output logic                  accumulate,
    output logic [ADDR_WIDTH-1:0] a_tile_addr,
    output logic [ADDR_WIDTH-1:0] b_tile_addr,
    output logic [ADDR_WIDTH-1:0] c_tile_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
`ifdef PERF_COUNTER_EN
    output logic [31:0]           perf_cycles,
    output logic [23:0]           perf_launches,
`endif
    output seq_state_t            dbg_state
);

    // Engine handshake: start_mat_mul is held high until done_mat_mul is seen; the next launch
    // is only issued after done_mat_mul has returned low, so every launch gets one done pulse.

    localparam int TB_BYTES = tile_bytes(MAT_MUL_SIZE, DWIDTH);

    seq_state_t            state_q, state_d;
    logic                  start_q, start_d, acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [TILE_CNT_W-1:0] cnt_m_q, cnt_m_d, cnt_n_q, cnt_n_d, cnt_k_q, cnt_k_d;
    logic                  gen_init, gen_step, gen_k_zero, gen_last;
    logic [ADDR_WIDTH-1:0] gen_a, gen_b, gen_c;
    logic                  busy_w;

    matmul_tile_sequencer_tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TILE_CNT_W (TILE_CNT_W),
        .TILE_BYTES (TB_BYTES)
    ) u_tile_addr_gen (
        .clk      (clk),
        .resetn   (resetn),
        .init_i   (gen_init),
        .step_i   (gen_step),
        .cnt_m_i  (cnt_m_q),
        .cnt_n_i  (cnt_n_q),
        .cnt_k_i  (cnt_k_q),
        .base_a_i (base_addr_a),
        .base_b_i (base_addr_b),
        .base_c_i (base_addr_c),
        .a_addr_o (gen_a),
        .b_addr_o (gen_b),
        .c_addr_o (gen_c),
        .k_zero_o (gen_k_zero),
        .last_o   (gen_last)
    );

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cnt_m_d  = cnt_m_q;
        cnt_n_d  = cnt_n_q;
        cnt_k_d  = cnt_k_q;
        gen_init = 1'b0;
        gen_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_reg) begin
                    cnt_m_d  = num_tiles_m;
                    cnt_n_d  = num_tiles_n;
                    cnt_k_d  = num_tiles_k;
                    gen_init = 1'b1;
                    if (num_tiles_m == '0 || num_tiles_n == '0 || num_tiles_k == '0)
                        state_d = ST_ERR;
                    else
                        state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                a_d     = gen_a;
                b_d     = gen_b;
                c_d     = gen_c;
                acc_d   = !gen_k_zero;
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_mat_mul) begin
                    start_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!done_mat_mul)
                    state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (gen_last) begin
                    state_d = ST_DONE;
                end else begin
                    gen_step = 1'b1;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_DONE, ST_ERR: begin
                if (clear_done_reg)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            acc_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cnt_m_q <= '0;
            cnt_n_q <= '0;
            cnt_k_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_m_q <= cnt_m_d;
            cnt_n_q <= cnt_n_d;
            cnt_k_q <= cnt_k_d;
        end
    end

    assign busy_w        = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) ||
                           (state_q == ST_RELEASE) || (state_q == ST_ADVANCE);
    assign busy          = busy_w;
    assign done          = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERR);
    assign start_mat_mul = start_q;
    assign accumulate    = acc_q;
    assign a_tile_addr   = a_q;
    assign b_tile_addr   = b_q;
    assign c_tile_addr   = c_q;
    assign dbg_state     = state_q;

`ifdef PERF_COUNTER_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [23:0] perf_launches_q, perf_launches_d;

    // Both counters restart on the start that leaves IDLE and saturate instead of wrapping
    always_comb begin
        perf_cycles_d   = perf_cycles_q;
        perf_launches_d = perf_launches_q;
        if (state_q == ST_IDLE && start_reg) begin
            perf_cycles_d   = '0;
            perf_launches_d = '0;
        end else if (busy_w) begin
            if (perf_cycles_q != '1)
                perf_cycles_d = perf_cycles_q + 1'b1;
            if (state_q == ST_LAUNCH && perf_launches_q != '1)
                perf_launches_d = perf_launches_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cycles_q   <= '0;
            perf_launches_q <= '0;
        end else begin
            perf_cycles_q   <= perf_cycles_d;
            perf_launches_q <= perf_launches_d;
        end
    end

    assign perf_cycles   = perf_cycles_q;
    assign perf_launches = perf_launches_q;
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Self-checking bench for matmul_tile_sequencer: behavioural engine plus a launch scoreboard.
// Build with PERF_COUNTER_EN defined to also check the performance counters.
module tb_matmul_tile_sequencer;

    localparam int AW = 15;
    localparam int CW = 8;
    localparam int EW = 1 + 3 * AW;
    localparam int TILE_B = 16;

    logic          clk;
    logic          resetn;
    logic          start_reg;
    logic          clear_done_reg;
    logic [CW-1:0] num_tiles_m, num_tiles_n, num_tiles_k;
    logic [AW-1:0] base_addr_a, base_addr_b, base_addr_c;
    logic          start_mat_mul;
    logic          done_mat_mul;
    logic          accumulate;
    logic [AW-1:0] a_tile_addr, b_tile_addr, c_tile_addr;
    logic          busy, done, error;
    logic [2:0]    dbg_state;
`ifdef PERF_COUNTER_EN
    logic [31:0]   perf_cycles;
    logic [23:0]   perf_launches;
`endif

    logic [EW-1:0] exp_q[$];
    int            n_compared;
    int            n_mismatched;
    int            launches;
    int            eng_lat;
    int            eng_hold;
    bit            eng_busy;

    matmul_tile_sequencer dut (
        .clk            (clk),
        .resetn         (resetn),
        .start_reg      (start_reg),
        .clear_done_reg (clear_done_reg),
        .num_tiles_m    (num_tiles_m),
        .num_tiles_n    (num_tiles_n),
        .num_tiles_k    (num_tiles_k),
        .base_addr_a    (base_addr_a),
        .base_addr_b    (base_addr_b),
        .base_addr_c    (base_addr_c),
        .start_mat_mul  (start_mat_mul),
        .done_mat_mul   (done_mat_mul),
        .accumulate     (accumulate),
        .a_tile_addr    (a_tile_addr),
        .b_tile_addr    (b_tile_addr),
        .c_tile_addr    (c_tile_addr),
        .busy           (busy),
        .done           (done),
        .error          (error),
`ifdef PERF_COUNTER_EN
        .perf_cycles    (perf_cycles),
        .perf_launches  (perf_launches),
`endif
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one entry per tile in k-inner, n, m order
    task automatic push_tiles(input int nm, input int nn, input int nk,
                              input int ba, input int bb, input int bc);
        logic [AW-1:0] a, b, c;
        logic          acc;
        for (int m = 0; m < nm; m++)
            for (int n = 0; n < nn; n++)
                for (int k = 0; k < nk; k++) begin
                    a   = AW'(ba + (m * nk + k) * TILE_B);
                    b   = AW'(bb + (k * nn + n) * TILE_B);
                    c   = AW'(bc + (m * nn + n) * TILE_B);
                    acc = (k != 0);
                    exp_q.push_back({acc, a, b, c});
                end
    endtask

    // Behavioural engine: done after eng_lat cycles, held eng_hold cycles after start drops
    initial begin
        logic [EW-1:0] got, exp;
        int guard;
        done_mat_mul = 1'b0;
        eng_busy     = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && start_mat_mul) begin
                eng_busy = 1'b1;
                launches++;
                got = {accumulate, a_tile_addr, b_tile_addr, c_tile_addr};
                if (exp_q.size() == 0) begin
                    check("extra_launch", launches, launches - 1);
                end else begin
                    exp = exp_q.pop_front();
                    check("launch_tile", got, exp);
                end
                repeat (eng_lat - 1) @(negedge clk);
                if (resetn)
                    check("addr_stable", {accumulate, a_tile_addr, b_tile_addr, c_tile_addr}, got);
                done_mat_mul = 1'b1;
                guard = 0;
                while (start_mat_mul && guard < 1000) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 1000)
                    check("start_drop_timeout", start_mat_mul, 0);
                for (int i = 0; i < eng_hold; i++) begin
                    @(negedge clk);
                    check("no_relaunch_hold", start_mat_mul, 0);
                end
                done_mat_mul = 1'b0;
                eng_busy     = 1'b0;
            end
        end
    end

    // driver
    task automatic run_job(input int nm, input int nn, input int nk,
                           input int ba, input int bb, input int bc,
                           input int lat, input int hold,
                           input bit perturb, input bit clear_with_start);
        int guard;
        int exp_launch;
        eng_lat    = lat;
        eng_hold   = hold;
        launches   = 0;
        exp_launch = nm * nn * nk;
        push_tiles(nm, nn, nk, ba, bb, bc);
        @(negedge clk);
        num_tiles_m = CW'(nm);
        num_tiles_n = CW'(nn);
        num_tiles_k = CW'(nk);
        base_addr_a = AW'(ba);
        base_addr_b = AW'(bb);
        base_addr_c = AW'(bc);
        start_reg   = 1'b1;
        @(negedge clk);
        start_reg = 1'b0;
        if (perturb) begin
            num_tiles_m = 3;
            num_tiles_n = 1;
            num_tiles_k = 3;
            base_addr_a = 15'h7ff0;
            base_addr_b = 15'h1234;
            base_addr_c = 15'h0400;
            repeat (4) @(negedge clk);
            start_reg = 1'b1;
            @(negedge clk);
            start_reg = 1'b0;
        end
        guard = 0;
        while (!done && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", done, 1);
        check("busy_in_done", busy, 0);
        check("error_in_done", error, 0);
        check("launch_count", launches, exp_launch);
        check("sb_drained", exp_q.size(), 0);
`ifdef PERF_COUNTER_EN
        check("perf_launches", perf_launches, exp_launch);
        check("perf_cycles", perf_cycles, exp_launch * (lat + hold + 3));
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("done_held", done, 1);
`ifdef PERF_COUNTER_EN
        check("perf_cycles_held", perf_cycles, exp_launch * (lat + hold + 3));
`endif
        clear_done_reg = 1'b1;
        if (clear_with_start)
            start_reg = 1'b1;
        @(negedge clk);
        clear_done_reg = 1'b0;
        start_reg      = 1'b0;
        check("done_cleared", done, 0);
        check("idle_after_clear", dbg_state, 0);
        repeat (3) @(negedge clk);
        check("no_restart", busy, 0);
        check("no_extra_launch", launches, exp_launch);
    endtask

    initial begin
        int guard;
        n_compared     = 0;
        n_mismatched   = 0;
        launches       = 0;
        eng_lat        = 2;
        eng_hold       = 0;
        resetn         = 1'b0;
        start_reg      = 1'b0;
        clear_done_reg = 1'b0;
        num_tiles_m    = '0;
        num_tiles_n    = '0;
        num_tiles_k    = '0;
        base_addr_a    = '0;
        base_addr_b    = '0;
        base_addr_c    = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_outputs", {start_mat_mul, accumulate, busy, done, error}, 0);
        check("rst_addrs", {a_tile_addr, b_tile_addr, c_tile_addr}, 0);
        check("rst_state", dbg_state, 0);
`ifdef PERF_COUNTER_EN
        check("rst_perf", {perf_cycles, perf_launches}, 0);
`endif

        // single tile
        run_job(1, 1, 1, 'h000, 'h100, 'h200, 3, 0, 0, 0);
        // 2x2x2, config and start perturbed mid-run, clear+start together in DONE
        run_job(2, 2, 2, 0, 0, 0, 2, 0, 1, 1);

        // zero inner count
        @(negedge clk);
        num_tiles_m = 2;
        num_tiles_n = 2;
        num_tiles_k = 0;
        launches    = 0;
        start_reg   = 1'b1;
        @(negedge clk);
        start_reg = 1'b0;
        repeat (3) @(negedge clk);
        check("err_flag", error, 1);
        check("err_not_busy", {busy, done, start_mat_mul}, 0);
        check("err_launches", launches, 0);
`ifdef PERF_COUNTER_EN
        check("err_perf", {perf_cycles, perf_launches}, 0);
`endif
        clear_done_reg = 1'b1;
        @(negedge clk);
        clear_done_reg = 1'b0;
        check("err_cleared", error, 0);
        check("err_idle", dbg_state, 0);

        // engine holds done 5 cycles after each tile
        run_job(2, 3, 2, $urandom_range(0, 32767), $urandom_range(0, 32767),
                $urandom_range(0, 32767), 4, 5, 0, 0);

        // async reset during WAIT of tile 3
        eng_lat  = 20;
        eng_hold = 0;
        launches = 0;
        push_tiles(2, 2, 2, 0, 0, 0);
        @(negedge clk);
        num_tiles_m = 2;
        num_tiles_n = 2;
        num_tiles_k = 2;
        base_addr_a = '0;
        base_addr_b = '0;
        base_addr_c = '0;
        start_reg   = 1'b1;
        @(negedge clk);
        start_reg = 1'b0;
        guard = 0;
        while (launches < 3 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_tile3", launches, 3);
        repeat (3) @(negedge clk);
        check("tile3_in_wait", {dbg_state, start_mat_mul}, {3'd2, 1'b1});
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_start", start_mat_mul, 0);
        check("rst_async_outs", {accumulate, busy, done, error, dbg_state}, 0);
        check("rst_async_addrs", {a_tile_addr, b_tile_addr, c_tile_addr}, 0);
`ifdef PERF_COUNTER_EN
        check("rst_async_perf", {perf_cycles, perf_launches}, 0);
`endif
        exp_q.delete();
        guard = 0;
        while (eng_busy && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("engine_idle", eng_busy, 0);
        @(negedge clk);
        resetn = 1'b1;
        run_job(2, 2, 2, 'h40, 'h1000, 'h2000, 4, 1, 0, 0);

        // engine latency 10, checked against cycle model when counters exist
        run_job(2, 2, 2, 0, 0, 0, 10, 0, 0, 0);

        // randomised jobs, including address wrap near the top of the space
        for (int r = 0; r < 3; r++)
            run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                    $urandom_range(32000, 32767), $urandom_range(0, 32767),
                    $urandom_range(0, 32767), $urandom_range(1, 6), $urandom_range(0, 3), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
